// File: rtl/snake_button_ctrl.sv
// Divides CLOCK into SLOW_CLOCK and turns debounced button presses into one-slow-period request levels.
// Define SNAKE_TURN_QUEUE_EN to hold turns in a 2-entry FIFO instead of a single latest-wins register.
module snake_button_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HALF_PERIOD     = 2500000
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_centre,
    output logic SLOW_CLOCK,
    output logic left_pulse,
    output logic right_pulse,
    output logic start
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int unsigned BTN_L = 0;
    localparam int unsigned BTN_R = 1;
    localparam int unsigned BTN_C = 2;

    typedef enum logic [1:0] {
        TURN_NONE  = 2'd0,
        TURN_LEFT  = 2'd1,
        TURN_RIGHT = 2'd2
    } turn_t;

    logic [2:0]           btn_raw_c;
    logic [2:0]           sync_q1;
    logic [2:0]           sync_q2;
    logic [2:0]           level;
    logic [2:0][DB_W-1:0] db_cnt;
    logic [2:0]           press_c;
    turn_t                turn_req_c;
    turn_t                turn_head_c;
    logic [DIV_W-1:0]     div_cnt;
    logic                 div_tc_c;
    logic                 fall_c;
    logic                 start_pend;
    logic                 start_pend_next;

    assign btn_raw_c = {btn_centre, btn_right, btn_left};

    // Two-flop synchroniser followed by a per-button stability counter
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
            level   <= '0;
            db_cnt  <= '0;
        end else begin
            sync_q1 <= btn_raw_c;
            sync_q2 <= sync_q1;
            for (int i = 0; i < 3; i++) begin
                if (sync_q2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES)) begin
                    level[i]  <= sync_q2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // A press is the cycle in which an accepted level flips 0->1
    always_comb begin
        press_c = '0;
        for (int i = 0; i < 3; i++) begin
            press_c[i] = sync_q2[i] && !level[i] && (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES));
        end
        turn_req_c = TURN_NONE;
        if (press_c[BTN_L] && !press_c[BTN_R]) begin
            turn_req_c = TURN_LEFT;
        end else if (press_c[BTN_R] && !press_c[BTN_L]) begin
            turn_req_c = TURN_RIGHT;
        end
    end

    assign div_tc_c = (div_cnt == DIV_W'(HALF_PERIOD - 1));
    assign fall_c   = div_tc_c && SLOW_CLOCK;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            div_cnt    <= '0;
            SLOW_CLOCK <= 1'b0;
        end else if (div_tc_c) begin
            div_cnt    <= '0;
            SLOW_CLOCK <= ~SLOW_CLOCK;
        end else begin
            div_cnt    <= div_cnt + DIV_W'(1);
        end
    end

    // Pending start: cleared on transfer, then a same-cycle press re-arms it
    always_comb begin
        start_pend_next = start_pend;
        if (fall_c) begin
            start_pend_next = 1'b0;
        end
        if (press_c[BTN_C]) begin
            start_pend_next = 1'b1;
        end
    end

`ifdef SNAKE_TURN_QUEUE_EN
    turn_t       head_q;
    turn_t       tail_q;
    turn_t       head_next;
    turn_t       tail_next;
    logic [1:0]  fill_q;
    logic [1:0]  fill_next;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            head_q     <= TURN_NONE;
            tail_q     <= TURN_NONE;
            fill_q     <= 2'd0;
            start_pend <= 1'b0;
        end else begin
            head_q     <= head_next;
            tail_q     <= tail_next;
            fill_q     <= fill_next;
            start_pend <= start_pend_next;
        end
    end

    // Pop (or flush on start) first, then push; a full FIFO overwrites its newest entry
    always_comb begin
        head_next = head_q;
        tail_next = tail_q;
        fill_next = fill_q;
        if (fall_c) begin
            if (start_pend) begin
                fill_next = 2'd0;
            end else if (fill_q != 2'd0) begin
                head_next = tail_q;
                fill_next = fill_q - 2'd1;
            end
        end
        if (turn_req_c != TURN_NONE) begin
            case (fill_next)
                2'd0: begin
                    head_next = turn_req_c;
                    fill_next = 2'd1;
                end
                2'd1: begin
                    tail_next = turn_req_c;
                    fill_next = 2'd2;
                end
                default: tail_next = turn_req_c;
            endcase
        end
    end

    assign turn_head_c = (fill_q != 2'd0) ? head_q : TURN_NONE;
`else
    turn_t turn_pend;
    turn_t turn_pend_next;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            turn_pend  <= TURN_NONE;
            start_pend <= 1'b0;
        end else begin
            turn_pend  <= turn_pend_next;
            start_pend <= start_pend_next;
        end
    end

    // Latest press wins; simultaneous left+right leaves the pending turn alone
    always_comb begin
        turn_pend_next = turn_pend;
        if (fall_c) begin
            turn_pend_next = TURN_NONE;
        end
        if (turn_req_c != TURN_NONE) begin
            turn_pend_next = turn_req_c;
        end
    end

    assign turn_head_c = turn_pend;
`endif

    // Outputs only move on fall cycles; a pending start suppresses any turn
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            left_pulse  <= 1'b0;
            right_pulse <= 1'b0;
            start       <= 1'b1;
        end else if (fall_c) begin
            left_pulse  <= !start_pend && (turn_head_c == TURN_LEFT);
            right_pulse <= !start_pend && (turn_head_c == TURN_RIGHT);
            start       <= start_pend;
        end
    end

endmodule

// File: tb/tb_snake_button_ctrl.sv
// Directed bench for snake_button_ctrl (DEBOUNCE_CYCLES=4, HALF_PERIOD=5) with a cycle-indexed expectation queue.
module tb_snake_button_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned HP = 5;
    localparam int SIG_SLOW  = 0;
    localparam int SIG_LEFT  = 1;
    localparam int SIG_RIGHT = 2;
    localparam int SIG_START = 3;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    logic btn_left = 1'b0;
    logic btn_right = 1'b0;
    logic btn_centre = 1'b0;
    logic SLOW_CLOCK;
    logic left_pulse;
    logic right_pulse;
    logic start;

    snake_button_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .HALF_PERIOD    (HP)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_centre (btn_centre),
        .SLOW_CLOCK (SLOW_CLOCK),
        .left_pulse (left_pulse),
        .right_pulse(right_pulse),
        .start      (start)
    );

    always #5 CLOCK = ~CLOCK;

    // Edges since reset release; sampled at the following negedge
    int cyc;
    always @(posedge CLOCK or posedge RESET) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        int    cyc;
        int    sig;
        logic  val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic obs(input int sig);
        case (sig)
            SIG_SLOW:  return SLOW_CLOCK;
            SIG_LEFT:  return left_pulse;
            SIG_RIGHT: return right_pulse;
            default:   return start;
        endcase
    endfunction

    task automatic expect_win(input int sig, input int lo, input int hi, input logic val, input string tag);
        for (int c = lo; c <= hi; c++) sb.push_back('{cyc: c, sig: sig, val: val, tag: tag});
    endtask

    task automatic check_now(input int sig, input logic val, input string tag);
        logic ob;
        ob = obs(sig);
        n_tests++;
        assert (ob === val) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, ob, val);
        end
    endtask

    // Advance one cycle, then retire every expectation due by now
    task automatic tick();
        logic ob;
        @(negedge CLOCK);
        if (!RESET) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    ob = obs(sb[i].sig);
                    n_tests++;
                    assert (ob === sb[i].val && sb[i].cyc == cyc) else begin
                        n_fail++;
                        $error("FAIL %s @cyc %0d (due %0d): observed %b expected %b",
                               sb[i].tag, cyc, sb[i].cyc, ob, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    initial begin
        // Reset state, then first rise at 5 and first fall at 10
        RESET = 1'b1;
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        check_now(SIG_START, 1'b1, "reset_start");
        check_now(SIG_SLOW,  1'b0, "reset_slow");
        check_now(SIG_LEFT,  1'b0, "reset_left");
        check_now(SIG_RIGHT, 1'b0, "reset_right");
        RESET = 1'b0;
        expect_win(SIG_SLOW,  1, 4,  1'b0, "div_low0");
        expect_win(SIG_SLOW,  5, 9,  1'b1, "div_first_rise");
        expect_win(SIG_SLOW,  10, 14, 1'b0, "div_first_fall");
        expect_win(SIG_SLOW,  15, 19, 1'b1, "div_second_rise");
        expect_win(SIG_START, 1, 9,  1'b1, "start_init");
        expect_win(SIG_START, 10, 29, 1'b0, "start_drop");
        expect_win(SIG_RIGHT, 1, 29, 1'b0, "right_idle");

        // Bounce on left: 2-cycle toggles never survive debounce
        wait_until(12);
        expect_win(SIG_LEFT, 13, 69, 1'b0, "bounce_no_left");
        for (int i = 0; i < 5; i++) begin
            btn_left = 1'b1;
            tick(); tick();
            btn_left = 1'b0;
            tick(); tick();
        end

        // Clean 10-cycle left press: event at 67, presented 70..79
        wait_until(60);
        expect_win(SIG_LEFT,  70, 79, 1'b1, "deb_left_on");
        expect_win(SIG_LEFT,  80, 89, 1'b0, "deb_left_off");
        expect_win(SIG_SLOW,  70, 74, 1'b0, "deb_slow_low");
        expect_win(SIG_SLOW,  75, 79, 1'b1, "deb_slow_high");
        expect_win(SIG_START, 70, 79, 1'b0, "deb_start");
        expect_win(SIG_RIGHT, 70, 79, 1'b0, "deb_right");
        btn_left = 1'b1;
        repeat (10) tick();
        btn_left = 1'b0;

        // Left event 107, right event 109, both before the fall at 110
        wait_until(100);
`ifdef SNAKE_TURN_QUEUE_EN
        expect_win(SIG_LEFT,  110, 119, 1'b1, "q_left_first");
        expect_win(SIG_RIGHT, 110, 119, 1'b0, "q_right_wait");
        expect_win(SIG_RIGHT, 120, 129, 1'b1, "q_right_second");
        expect_win(SIG_LEFT,  120, 129, 1'b0, "q_left_done");
`else
        expect_win(SIG_RIGHT, 110, 119, 1'b1, "latest_right");
        expect_win(SIG_LEFT,  110, 119, 1'b0, "latest_no_left");
        expect_win(SIG_RIGHT, 120, 129, 1'b0, "latest_right_off");
        expect_win(SIG_LEFT,  120, 129, 1'b0, "latest_left_off");
`endif
        expect_win(SIG_LEFT,  130, 139, 1'b0, "latest_idle_l");
        expect_win(SIG_RIGHT, 130, 139, 1'b0, "latest_idle_r");
        btn_left = 1'b1;
        tick(); tick();
        btn_right = 1'b1;
        repeat (4) tick();
        btn_left = 1'b0;
        tick(); tick();
        btn_right = 1'b0;

        // Left and right events in the same cycle (148) cancel
        wait_until(141);
        expect_win(SIG_LEFT,  150, 159, 1'b0, "simul_left");
        expect_win(SIG_RIGHT, 150, 159, 1'b0, "simul_right");
        btn_left  = 1'b1;
        btn_right = 1'b1;
        repeat (6) tick();
        btn_left  = 1'b0;
        btn_right = 1'b0;

        // Left event lands on the fall cycle 170: skipped there, shown at 180
        wait_until(163);
        expect_win(SIG_LEFT, 170, 179, 1'b0, "edge_not_now");
        expect_win(SIG_LEFT, 180, 189, 1'b1, "edge_next_fall");
        expect_win(SIG_LEFT, 190, 199, 1'b0, "edge_after");
        btn_left = 1'b1;
        repeat (6) tick();
        btn_left = 1'b0;

        // Centre and left in the same period: start wins, nothing follows
        wait_until(200);
        expect_win(SIG_START, 210, 219, 1'b1, "prio_start");
        expect_win(SIG_LEFT,  210, 219, 1'b0, "prio_no_left");
        expect_win(SIG_START, 220, 229, 1'b0, "prio_start_off");
        expect_win(SIG_LEFT,  220, 229, 1'b0, "prio_left_off");
        expect_win(SIG_RIGHT, 210, 229, 1'b0, "prio_right");
        btn_centre = 1'b1;
        btn_left   = 1'b1;
        repeat (6) tick();
        btn_centre = 1'b0;
        btn_left   = 1'b0;

        // Right pulse in flight when RESET hits mid-cycle
        wait_until(230);
        expect_win(SIG_RIGHT, 240, 243, 1'b1, "mid_right_on");
        btn_right = 1'b1;
        repeat (6) tick();
        btn_right = 1'b0;
        wait_until(243);
        #2 RESET = 1'b1;
        #1;
        check_now(SIG_RIGHT, 1'b0, "mid_rst_right");
        check_now(SIG_START, 1'b1, "mid_rst_start");
        check_now(SIG_LEFT,  1'b0, "mid_rst_left");
        tick();
        tick();
        RESET = 1'b0;
        expect_win(SIG_START, 1, 9,   1'b1, "rerst_start");
        expect_win(SIG_START, 10, 12, 1'b0, "rerst_start_drop");
        expect_win(SIG_RIGHT, 1, 12,  1'b0, "rerst_right");
        expect_win(SIG_SLOW,  5, 5,   1'b1, "rerst_rise");
        wait_until(15);

        for (int k = 0; k < 100 && sb.size() != 0; k++) tick();
        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL drain: %0d expectations unchecked, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
